// File: rtl/mlp_eval_sequencer.sv
// Evaluation sequencer for the MLP core. It issues classification jobs, waits for
// each result with a timeout, checks it against label memory and counts hits.
module mlp_eval_sequencer #(
    parameter int             IDX_W       = 10,
    parameter int             NUM_SAMPLES = 750,
    parameter int             CLS_W       = 4,
    parameter int             CNT_W       = 16,
    parameter int             TIMEOUT     = 255,
    parameter logic [IDX_W-1:0] LFSR_SEED = IDX_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic             mode,
    input  logic [IDX_W-1:0] base_idx,
    input  logic [CNT_W-1:0] num_tests,
    output logic             mlp_rst,
    output logic             mlp_start,
    output logic [IDX_W-1:0] test_num,
    input  logic [CLS_W-1:0] mlp_out,
    input  logic             mlp_done,
    output logic             label_rd,
    input  logic [CLS_W-1:0] label,
    output logic             busy,
    output logic             finished,
    output logic [CNT_W-1:0] tested_cnt,
    output logic [CNT_W-1:0] correct_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    // Maximal-length tap masks for a shift-left Fibonacci LFSR.
    function automatic logic [IDX_W-1:0] lfsr_taps();
        logic [31:0] m;
        case (IDX_W)
            2:       m = 32'h0003;
            3:       m = 32'h0006;
            4:       m = 32'h000C;
            5:       m = 32'h0014;
            6:       m = 32'h0030;
            7:       m = 32'h0060;
            8:       m = 32'h00B8;
            9:       m = 32'h0110;
            10:      m = 32'h0240;
            11:      m = 32'h0500;
            12:      m = 32'h0829;
            13:      m = 32'h100D;
            14:      m = 32'h2015;
            15:      m = 32'h6000;
            16:      m = 32'hD008;
            default: m = 32'h0240;
        endcase
        return m[IDX_W-1:0];
    endfunction

    localparam int               TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] TAPS     = lfsr_taps();
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [IDX_W:0]   NS_EXT   = (IDX_W + 1)'(NUM_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_CLR,
        S_ISSUE,
        S_WAIT,
        S_CMP,
        S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] num_lat;
    logic             mode_lat;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] lfsr;
    logic [IDX_W-1:0] lfsr_nxt;
    logic             lfsr_ok;
    logic [TW-1:0]    wait_ctr;
    logic [CLS_W-1:0] captured;
    logic             timed_out;
    logic [CNT_W-1:0] tested_inc;
    logic             wait_expired;

    assign lfsr_nxt     = {lfsr[IDX_W-2:0], ^(lfsr & TAPS)};
    assign lfsr_ok      = {1'b0, lfsr_nxt} < NS_EXT;
    assign tested_inc   = tested_cnt + CNT_W'(1);
    assign wait_expired = (wait_ctr == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_FIN: begin
                    if (go) state_nxt = (num_tests == '0) ? S_FIN : S_PICK;
                end
                S_PICK:  if (!mode_lat || lfsr_ok) state_nxt = S_CLR;
                S_CLR:   state_nxt = S_ISSUE;
                S_ISSUE: state_nxt = S_WAIT;
                S_WAIT:  if (mlp_done || wait_expired) state_nxt = S_CMP;
                S_CMP:   state_nxt = (tested_inc == num_lat) ? S_FIN : S_PICK;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign mlp_rst   = (state == S_CLR);
    assign mlp_start = (state == S_ISSUE);
    assign label_rd  = (state == S_CMP);
    assign finished  = (state == S_FIN);
    assign busy      = (state != S_IDLE) && (state != S_FIN);

    // Abort freezes the datapath so counters keep their mid-run values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_lat     <= '0;
            mode_lat    <= 1'b0;
            ptr         <= '0;
            lfsr        <= LFSR_SEED;
            test_num    <= '0;
            wait_ctr    <= '0;
            captured    <= '0;
            timed_out   <= 1'b0;
            tested_cnt  <= '0;
            correct_cnt <= '0;
            timeout_cnt <= '0;
        end else if (!abort) begin
            case (state)
                S_IDLE, S_FIN: begin
                    if (go) begin
                        num_lat     <= num_tests;
                        mode_lat    <= mode;
                        ptr         <= base_idx;
                        tested_cnt  <= '0;
                        correct_cnt <= '0;
                        timeout_cnt <= '0;
                    end
                end
                S_PICK: begin
                    if (!mode_lat) begin
                        test_num <= ptr;
                        ptr      <= (ptr == LAST_IDX) ? '0 : ptr + IDX_W'(1);
                    end else begin
                        lfsr <= lfsr_nxt;
                        if (lfsr_ok) test_num <= lfsr_nxt;
                    end
                end
                S_ISSUE: begin
                    wait_ctr  <= '0;
                    timed_out <= 1'b0;
                end
                S_WAIT: begin
                    if (mlp_done) begin
                        captured <= mlp_out;
                    end else if (wait_expired) begin
                        timed_out <= 1'b1;
                    end else begin
                        wait_ctr <= wait_ctr + TW'(1);
                    end
                end
                S_CMP: begin
                    tested_cnt <= tested_inc;
                    if (timed_out)              timeout_cnt <= timeout_cnt + CNT_W'(1);
                    else if (captured == label) correct_cnt <= correct_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
